// File: rtl/mmi_cmd_engine.sv
// Byte-wide command executor for the peripheral register block: WRITE, FILL, COPY
// and READ against a local SRAM, with busy/done handshake and sticky error flags.
module mmi_cmd_engine #(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd,
    input  logic [7:0]        data,
    input  logic [MEM_AW-1:0] addr_src,
    input  logic [MEM_AW-1:0] addr_dest,
    input  logic [7:0]        addr_th,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rd_data,
    output logic              err_cmd,
    output logic              err_busy
);

    localparam logic [7:0] OP_CLR   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_FILL  = 8'h02;
    localparam logic [7:0] OP_COPY  = 8'h03;
    localparam logic [7:0] OP_READ  = 8'h04;

    typedef enum logic [2:0] {
        IDLE, WR1, FILL, CP_RD, CP_WR, RD_REQ, RD_CAP
    } state_t;

    typedef struct packed {
        logic [7:0]        data;
        logic [MEM_AW-1:0] src;
        logic [MEM_AW-1:0] dst;
        logic [7:0]        len;
    } op_t;

    state_t            state, state_n;
    op_t               op, op_n;
    logic [7:0]        idx, idx_n;
    logic [MEM_AW-1:0] addr_q, addr_n;
    logic [7:0]        wdata_q, wdata_n;
    logic              we_q, we_n, re_q, re_n;
    logic              busy_q, busy_n, done_q, done_n;
    logic [7:0]        rd_q, rd_n;
    logic              errc_q, errc_n, errb_q, errb_n;
    logic              last;

    assign last = (idx == op.len - 8'd1);

    always_comb begin
        state_n = state;
        op_n    = op;
        idx_n   = idx;
        addr_n  = '0;
        wdata_n = wdata_q;
        we_n    = 1'b0;
        re_n    = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        rd_n    = rd_q;
        errc_n  = errc_q;
        errb_n  = errb_q;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_n  = '{data, addr_src, addr_dest, addr_th};
                    idx_n = 8'd0;
                    case (cmd)
                        OP_CLR: begin
                            errc_n = 1'b0;
                            errb_n = 1'b0;
                            done_n = 1'b1;
                        end
                        OP_WRITE: begin
                            state_n = WR1;
                            we_n    = 1'b1;
                            addr_n  = addr_dest;
                            wdata_n = data;
                            busy_n  = 1'b1;
                        end
                        OP_FILL: begin
                            if (addr_th == 8'd0) begin
                                done_n = 1'b1;
                            end else begin
                                state_n = FILL;
                                we_n    = 1'b1;
                                addr_n  = addr_dest;
                                wdata_n = data;
                                busy_n  = 1'b1;
                            end
                        end
                        OP_COPY: begin
                            if (addr_th == 8'd0) begin
                                done_n = 1'b1;
                            end else begin
                                state_n = CP_RD;
                                re_n    = 1'b1;
                                addr_n  = addr_src;
                                busy_n  = 1'b1;
                            end
                        end
                        OP_READ: begin
                            state_n = RD_REQ;
                            re_n    = 1'b1;
                            addr_n  = addr_src;
                            busy_n  = 1'b1;
                        end
                        default: begin
                            errc_n = 1'b1;
                            done_n = 1'b1;
                        end
                    endcase
                end
            end
            WR1: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            FILL: begin
                if (last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    idx_n  = idx + 8'd1;
                    we_n   = 1'b1;
                    addr_n = MEM_AW'(op.dst + idx_n);
                    busy_n = 1'b1;
                end
            end
            CP_RD: begin
                state_n = CP_WR;
                we_n    = 1'b1;
                addr_n  = MEM_AW'(op.dst + idx);
                busy_n  = 1'b1;
            end
            CP_WR: begin
                if (last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = CP_RD;
                    idx_n   = idx + 8'd1;
                    re_n    = 1'b1;
                    addr_n  = MEM_AW'(op.src + idx_n);
                    busy_n  = 1'b1;
                end
            end
            RD_REQ: begin
                state_n = RD_CAP;
                busy_n  = 1'b1;
            end
            RD_CAP: begin
                state_n = IDLE;
                rd_n    = mem_rdata;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // Commands arriving mid-operation are dropped; only the flag records them.
        if (cmd_valid && state != IDLE) errb_n = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op      <= '0;
            idx     <= 8'd0;
            addr_q  <= '0;
            wdata_q <= 8'd0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 8'd0;
            errc_q  <= 1'b0;
            errb_q  <= 1'b0;
        end else begin
            state   <= state_n;
            op      <= op_n;
            idx     <= idx_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            we_q    <= we_n;
            re_q    <= re_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            rd_q    <= rd_n;
            errc_q  <= errc_n;
            errb_q  <= errb_n;
        end
    end

    // Copy write data comes straight from the SRAM's registered read port so the
    // write can land the cycle right after the read.
    assign mem_wdata = (state == CP_WR) ? mem_rdata : wdata_q;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_re    = re_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_data   = rd_q;
    assign err_cmd   = errc_q;
    assign err_busy  = errb_q;

endmodule
